// File: rtl/uart_tx_scheduler_if.sv
// Requester, arbitration and UART-side signals of the UART transmit scheduler.
// The scheduler takes the master modport; requesters and the UART take the slave modport.
interface uart_tx_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic               err;
  logic [N_REQ-1:0]   grant;
  logic [7:0]         tx_data;
  logic               tx_load;
  logic               tx_start;
  logic               tx_busy;
  logic               sched_busy;

  modport master (
    input  req, req_data, tx_busy,
    output ack, err, grant, tx_data, tx_load, tx_start, sched_busy
  );

  modport slave (
    output req, req_data, tx_busy,
    input  ack, err, grant, tx_data, tx_load, tx_start, sched_busy
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin owner of a shared UART transmitter: latch a byte, stretch the load and
// start strobes for the slow UART clock, wait out the frame, then acknowledge.
module uart_tx_scheduler #(
  parameter int N_REQ        = 4,
  parameter int STROBE_LEN   = 8,
  parameter int GAP_LEN      = 8,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic                 CLOCK_125_p,
  input  logic                 reset,
  uart_tx_scheduler_if.master  bus
);
  typedef enum logic [2:0] {IDLE, LOAD, GAP, START, WAIT_BUSY, WAIT_IDLE, ACK} state_t;

  localparam int PTR_W   = $clog2(N_REQ);
  localparam int MAX_LEN = (STROBE_LEN > GAP_LEN) ? STROBE_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  state_t             state_reg;
  logic [PTR_W-1:0]   ptr_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [15:0]        to_cnt_reg;
  logic [N_REQ-1:0]   ack_reg;
  logic [N_REQ-1:0]   grant_reg;
  logic               err_reg;
  logic [7:0]         tx_data_reg;
  logic               tx_load_reg;
  logic               tx_start_reg;
  logic               sched_busy_reg;

  logic [PTR_W-1:0]   winner_next;
  logic [PTR_W-1:0]   ptr_next;
  logic [PTR_W-1:0]   scan_idx;
  logic               found_next;
  logic [N_REQ-1:0]   winner_onehot;
  logic [7:0]         data_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign data_arr[gi]      = bus.req_data[8*gi +: 8];
      assign winner_onehot[gi] = (winner_next == PTR_W'(gi));
    end
  endgenerate

  // Scan from the highest rotated offset down so the first set bit at or after ptr wins.
  always_comb begin
    winner_next = '0;
    found_next  = 1'b0;
    scan_idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = PTR_W'((int'(ptr_reg) + k) % N_REQ);
      if (bus.req[scan_idx]) begin
        winner_next = scan_idx;
        found_next  = 1'b1;
      end
    end
  end

  assign ptr_next = (winner_next == PTR_W'(N_REQ - 1)) ? '0 : winner_next + 1'b1;

  always_ff @(posedge CLOCK_125_p) begin
    if (reset) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      cnt_reg        <= '0;
      to_cnt_reg     <= '0;
      ack_reg        <= '0;
      grant_reg      <= '0;
      err_reg        <= 1'b0;
      tx_data_reg    <= '0;
      tx_load_reg    <= 1'b0;
      tx_start_reg   <= 1'b0;
      sched_busy_reg <= 1'b0;
    end else begin
      ack_reg <= '0;
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (found_next) begin
            grant_reg      <= winner_onehot;
            tx_data_reg    <= data_arr[winner_next];
            ptr_reg        <= ptr_next;
            cnt_reg        <= '0;
            tx_load_reg    <= 1'b1;
            sched_busy_reg <= 1'b1;
            state_reg      <= LOAD;
          end
        end
        LOAD: begin
          if (cnt_reg == CNT_W'(STROBE_LEN - 1)) begin
            tx_load_reg <= 1'b0;
            cnt_reg     <= '0;
            state_reg   <= GAP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        GAP: begin
          if (cnt_reg == CNT_W'(GAP_LEN - 1)) begin
            tx_start_reg <= 1'b1;
            cnt_reg      <= '0;
            to_cnt_reg   <= '0;
            state_reg    <= START;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        START: begin
          if (cnt_reg == CNT_W'(STROBE_LEN - 1)) begin
            tx_start_reg <= 1'b0;
            cnt_reg      <= '0;
            state_reg    <= WAIT_BUSY;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_BUSY: begin
          // A UART that never reports busy still gets acknowledged, flagged as an error.
          if (bus.tx_busy) begin
            state_reg <= WAIT_IDLE;
          end else if (to_cnt_reg == 16'(BUSY_TIMEOUT - 1)) begin
            ack_reg   <= grant_reg;
            err_reg   <= 1'b1;
            state_reg <= ACK;
          end else begin
            to_cnt_reg <= to_cnt_reg + 16'd1;
          end
        end
        WAIT_IDLE: begin
          if (!bus.tx_busy) begin
            ack_reg   <= grant_reg;
            state_reg <= ACK;
          end
        end
        ACK: begin
          grant_reg      <= '0;
          sched_busy_reg <= 1'b0;
          state_reg      <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack        = ack_reg;
  assign bus.err        = err_reg;
  assign bus.grant      = grant_reg;
  assign bus.tx_data    = tx_data_reg;
  assign bus.tx_load    = tx_load_reg;
  assign bus.tx_start   = tx_start_reg;
  assign bus.sched_busy = sched_busy_reg;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus queues expected grants/acks,
// a negedge monitor pops and compares them and checks strobe shapes.
module tb_uart_tx_scheduler;
  localparam int N = 4;

  typedef struct {
    logic [3:0] grant;
    logic [7:0] data;
    logic       err;
    int         when;   // grant: expected cycle (-1 = any)
    int         mode;   // ack: 0 = one cycle after busy falls, 1 = 1024 after WAIT_BUSY entry
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #4 clk = ~clk;

  uart_tx_scheduler_if #(.N_REQ(N)) bus ();

  uart_tx_scheduler #(
    .N_REQ(N), .STROBE_LEN(8), .GAP_LEN(8), .BUSY_TIMEOUT(1024)
  ) dut (
    .CLOCK_125_p(clk),
    .reset(reset),
    .bus(bus)
  );

  exp_t gq[$];
  exp_t aq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int busy_fall_cyc = -1;
  int start_fall_cyc = -1;
  bit uart_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_g(input logic [3:0] g, input logic [7:0] d, input int when);
    gq.push_back('{g, d, 1'b0, when, 0});
  endtask

  task automatic exp_a(input logic [3:0] g, input logic [7:0] d, input logic e, input int mode);
    aq.push_back('{g, d, e, -1, mode});
  endtask

  task automatic wait_ack(input int budget);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.ack == 0 && t < budget);
    check("ack_arrived", 32'(bus.ack != 0), 1);
  endtask

  task automatic wait_start(input logic val, input int budget);
    int t;
    t = 0;
    while (bus.tx_start !== val && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("wait_tx_start", bus.tx_start, val);
  endtask

  // UART model: busy rises 3 cycles after tx_start rises and stays high 100 cycles.
  logic u_prev_start = 1'b0;
  int start_seen_cyc = -1000;
  always @(negedge clk) begin
    if (reset) begin
      bus.tx_busy = 1'b0;
      start_seen_cyc = -1000;
      u_prev_start = 1'b0;
    end else begin
      if (uart_en && bus.tx_start && !u_prev_start) start_seen_cyc = cyc;
      if (uart_en && cyc == start_seen_cyc + 3) bus.tx_busy = 1'b1;
      if (bus.tx_busy && cyc == start_seen_cyc + 103) begin
        bus.tx_busy = 1'b0;
        busy_fall_cyc = cyc;
      end
      u_prev_start = bus.tx_start;
    end
  end

  logic prev_load = 1'b0;
  logic prev_start = 1'b0;
  logic [3:0] prev_grant = '0;
  int load_run = 0;
  int start_run = 0;
  int gap_run = 0;
  bit in_gap = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      prev_load = 1'b0; prev_start = 1'b0; prev_grant = '0;
      load_run = 0; start_run = 0; gap_run = 0; in_gap = 1'b0;
    end else begin
      if (bus.grant != 0 && prev_grant == 0) begin
        if (gq.size() == 0) check("unexpected_grant", bus.grant, 0);
        else begin
          e = gq.pop_front();
          check("grant", bus.grant, e.grant);
          check("grant_tx_data", bus.tx_data, e.data);
          if (e.when >= 0) check("grant_latency_cycle", cyc, e.when);
        end
      end
      if (bus.ack != 0) begin
        if (aq.size() == 0) check("unexpected_ack", bus.ack, 0);
        else begin
          e = aq.pop_front();
          check("ack", bus.ack, e.grant);
          check("err", bus.err, e.err);
          check("ack_tx_data", bus.tx_data, e.data);
          if (e.mode == 0) check("ack_after_busy_fall", cyc, busy_fall_cyc + 1);
          else check("ack_after_timeout", cyc, start_fall_cyc + 1024);
        end
      end else if (bus.err) begin
        check("err_without_ack", bus.err, 0);
      end
      if (bus.tx_load || bus.tx_start) check("strobe_overlap", bus.tx_load & bus.tx_start, 0);
      if (bus.tx_load) load_run++;
      if (!bus.tx_load && prev_load) begin
        check("tx_load_len", load_run, 8);
        load_run = 0; gap_run = 1; in_gap = 1'b1;
      end else if (in_gap) begin
        if (bus.tx_start) begin
          check("gap_len", gap_run, 8);
          in_gap = 1'b0;
        end else gap_run++;
      end
      if (bus.tx_start) start_run++;
      if (!bus.tx_start && prev_start) begin
        check("tx_start_len", start_run, 8);
        start_run = 0;
        start_fall_cyc = cyc;
      end
      prev_load = bus.tx_load;
      prev_start = bus.tx_start;
      prev_grant = bus.grant;
    end
  end

  initial begin
    bus.req = '0;
    bus.req_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_grant", bus.grant, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_err", bus.err, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_tx_load", bus.tx_load, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_sched_busy", bus.sched_busy, 0);
    reset = 1'b0;
    uart_en = 1'b1;

    // Single request from requester 1.
    @(negedge clk);
    bus.req_data[15:8] = 8'h0F;
    bus.req = 4'b0010;
    exp_g(4'b0010, 8'h0F, cyc + 1);
    exp_a(4'b0010, 8'h0F, 1'b0, 0);
    @(negedge clk);
    check("sched_busy_after_grant", bus.sched_busy, 1);
    wait_ack(400);
    bus.req = '0;

    // Reset during LOAD aborts with no ack; pointer returns to 0.
    @(negedge clk);
    bus.req_data[23:16] = 8'hC3;
    bus.req = 4'b0100;
    exp_g(4'b0100, 8'hC3, -1);
    repeat (4) @(negedge clk);
    check("in_load_before_reset", bus.tx_load, 1);
    reset = 1'b1;
    bus.req = '0;
    @(negedge clk);
    check("abort_grant", bus.grant, 0);
    check("abort_tx_load", bus.tx_load, 0);
    check("abort_tx_data", bus.tx_data, 0);
    check("abort_sched_busy", bus.sched_busy, 0);
    check("abort_ack", bus.ack, 0);
    @(negedge clk);
    reset = 1'b0;

    // Fairness under continuous requests: 0,1,2,3,0.
    @(negedge clk);
    bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_g(4'b0001 << (i % 4), 8'hA0 + 8'(i % 4), -1);
      exp_a(4'b0001 << (i % 4), 8'hA0 + 8'(i % 4), 1'b0, 0);
    end
    for (int i = 0; i < 5; i++) wait_ack(400);
    bus.req = '0;

    // Pointer wrap: serve 3, then 1001 picks 0, then 3.
    @(negedge clk);
    bus.req_data[31:24] = 8'h3C;
    bus.req = 4'b1000;
    exp_g(4'b1000, 8'h3C, -1);
    exp_a(4'b1000, 8'h3C, 1'b0, 0);
    wait_ack(400);
    bus.req = '0;
    @(negedge clk);
    bus.req_data[7:0] = 8'h5A;
    bus.req = 4'b1001;
    exp_g(4'b0001, 8'h5A, -1);
    exp_a(4'b0001, 8'h5A, 1'b0, 0);
    exp_g(4'b1000, 8'h3C, -1);
    exp_a(4'b1000, 8'h3C, 1'b0, 0);
    wait_ack(400);
    bus.req = 4'b1000;
    wait_ack(400);
    bus.req = '0;

    // Busy timeout on requester 1, then requester 2 served normally.
    @(negedge clk);
    uart_en = 1'b0;
    bus.req_data[15:8] = 8'h55;
    bus.req_data[23:16] = 8'h66;
    bus.req = 4'b0110;
    exp_g(4'b0010, 8'h55, -1);
    exp_a(4'b0010, 8'h55, 1'b1, 1);
    exp_g(4'b0100, 8'h66, -1);
    exp_a(4'b0100, 8'h66, 1'b0, 0);
    wait_ack(1300);
    uart_en = 1'b1;
    bus.req = 4'b0100;
    wait_ack(400);
    bus.req = '0;

    // Data hold: change data and drop req while in WAIT_IDLE.
    @(negedge clk);
    bus.req_data[7:0] = 8'h77;
    bus.req = 4'b0001;
    exp_g(4'b0001, 8'h77, -1);
    exp_a(4'b0001, 8'h77, 1'b0, 0);
    wait_start(1'b1, 100);
    wait_start(1'b0, 20);
    @(negedge clk);
    check("busy_in_wait_idle", bus.tx_busy, 1);
    bus.req_data[7:0] = 8'hEE;
    bus.req = '0;
    @(negedge clk);
    check("hold_tx_data", bus.tx_data, 8'h77);
    wait_ack(300);
    repeat (20) @(negedge clk);
    check("no_regrant", bus.grant, 0);
    check("idle_sched_busy", bus.sched_busy, 0);
    check("grant_queue_drained", gq.size(), 0);
    check("ack_queue_drained", aq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by cycle %0d expected bench to finish", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
